// File: rtl/dm_pkg.sv
// ============================================================================
// Module   : dm_pkg
// Brief    : Load/store type encodings and clear-FSM state enum for the
//            byte-selectable data memory.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dm_pkg;

    localparam logic [2:0] LS_W  = 3'd0;
    localparam logic [2:0] LS_H  = 3'd1;
    localparam logic [2:0] LS_HU = 3'd2;
    localparam logic [2:0] LS_B  = 3'd3;
    localparam logic [2:0] LS_BU = 3'd4;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_e;

endpackage

`default_nettype wire

// File: rtl/dm_lane_align.sv
// ============================================================================
// Module   : dm_lane_align
// Brief    : Byte-enable generation, store merge, load extract/extend and
//            misalignment detection for one 32-bit word.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  ls_type_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] w_wsh;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        case (addr_lo_i)
            2'd0:    w_byte = rword_i[7:0];
            2'd1:    w_byte = rword_i[15:8];
            2'd2:    w_byte = rword_i[23:16];
            default: w_byte = rword_i[31:24];
        endcase
    end

    // Store data is replicated across all lanes so the byte enables alone
    // pick which lanes land in the merged word.
    always_comb begin
        be_o       = 4'b0000;
        w_wsh      = 32'h0;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (ls_type_i)
            LS_W: begin
                misalign_o = (addr_lo_i != 2'b00);
                be_o       = 4'b1111;
                w_wsh      = wd_i;
                rdata_o    = rword_i;
            end
            LS_H, LS_HU: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                w_wsh      = {2{wd_i[15:0]}};
                rdata_o    = (ls_type_i == LS_H) ? {{16{w_half[15]}}, w_half}
                                                 : {16'h0, w_half};
            end
            LS_B, LS_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                w_wsh   = {4{wd_i[7:0]}};
                rdata_o = (ls_type_i == LS_B) ? {{24{w_byte[7]}}, w_byte}
                                              : {24'h0, w_byte};
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
        if (misalign_o) begin
            be_o    = 4'b0000;
            rdata_o = 32'h0;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_o[8*gi +: 8] = be_o[gi] ? w_wsh[8*gi +: 8]
                                                  : rword_i[8*gi +: 8];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/data_mem_bytesel.sv
// ============================================================================
// Module   : data_mem_bytesel
// Brief    : Word-organised data memory with byte/half/word access, a
//            post-reset hardware clear and optional store trace (DM_TRACE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_mem_bytesel
    import dm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        DMwrite,
    input  logic [2:0]  ls_type,
    input  logic [31:0] PC8_M,
    output logic [31:0] dataout,
    output logic        busy,
    output logic        addr_err
);

    logic [31:0]      mem_q [DEPTH];
    dm_state_e        state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword;
    logic [31:0]      w_merged;
    logic [31:0]      w_rdata;
    logic [3:0]       w_be;
    logic             w_misalign;
    logic             w_clear_we;
    logic             w_store_we;
    logic             w_unused_addr;

    assign w_idx         = Addr[IDX_W+1:2];
    assign w_unused_addr = ^Addr[31:IDX_W+2];
    assign w_rword       = mem_q[w_idx];

    dm_lane_align u_lane_align (
        .addr_lo_i  (Addr[1:0]),
        .ls_type_i  (ls_type),
        .wd_i       (WD),
        .rword_i    (w_rword),
        .be_o       (w_be),
        .merged_o   (w_merged),
        .rdata_o    (w_rdata),
        .misalign_o (w_misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + IDX_W'(1);
                if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                clr_ptr_d = '0;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    assign busy       = (state_q == ST_CLEAR);
    assign addr_err   = w_misalign;
    assign dataout    = (busy || w_misalign) ? 32'h0 : w_rdata;
    // The reset term keeps word 0 untouched while reset is held; state_q is
    // already CLEAR then, so without it every held edge would write.
    assign w_clear_we = busy && !reset;
    assign w_store_we = DMwrite && !busy && !w_misalign && (w_be != 4'b0000);

    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            mem_q[clr_ptr_q] <= 32'h0;
        end else if (w_store_we) begin
            mem_q[w_idx] <= w_merged;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (w_store_we) begin
            $display("%d@%h: *%h <= %h", $time, PC8_M - 32'd8,
                     {Addr[31:2], 2'b00}, w_merged);
        end
    end
`else
    logic w_unused_pc8;
    assign w_unused_pc8 = ^PC8_M;
`endif

endmodule

`default_nettype wire

// File: doc/data_mem_bytesel.md
DATA_MEM_BYTESEL -- requirements
Module: data_mem_bytesel

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the number of 32-bit words; it is a power of two and at least 4.
REQ-002 Parameter IDX_W, default $clog2(DEPTH), SHALL set the word-index width taken from Addr[IDX_W+1:2].
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port Addr, input, 32, SHALL be the byte address.
REQ-006 Port WD, input, 32, SHALL be the store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 Port DMwrite, input, 1, SHALL request a store in the current cycle.
REQ-008 Port ls_type, input, 3, SHALL select the access width and extension (encodings in dm_pkg).
REQ-009 Port PC8_M, input, 32, SHALL carry the store instruction's PC+8, used only by the trace.
REQ-010 Port dataout, output, 32, SHALL be the extended load result.
REQ-011 Port busy, output, 1, SHALL be high while post-reset clearing is in progress.
REQ-012 Port addr_err, output, 1, SHALL flag a misaligned access or a reserved ls_type.

Function
REQ-013 FSM states: CLEAR and READY; the word pointer clr_ptr is IDX_W bits wide.
REQ-014 In CLEAR, each clock edge SHALL write 0 to word clr_ptr and increment clr_ptr; the edge that writes word DEPTH-1 SHALL move the FSM to READY.
REQ-015 busy SHALL equal (state==CLEAR); clearing SHALL take exactly DEPTH edges after reset deassertion.
REQ-016 While busy: stores ignored; dataout=0; addr_err still computed.
REQ-017 Loads SHALL be combinational (same-cycle) from the word at Addr[IDX_W+1:2]; Addr bits above IDX_W+1 are ignored, so addresses wrap modulo 4*DEPTH.
REQ-018 A store SHALL update the array on the clock edge; the new value is visible on dataout from the following cycle, and the old value is shown in the store cycle.
REQ-019 Encodings: LS_W writes/reads the full word; LS_H/LS_HU use lane Addr[1]; LS_B/LS_BU use lane Addr[1:0]; on a store only the selected bytes change.
REQ-020 Loads: LS_H and LS_B sign-extend; LS_HU and LS_BU zero-extend.
REQ-021 addr_err=1 when LS_W with Addr[1:0]!=0, when LS_H/LS_HU with Addr[0]=1, or when ls_type is reserved (5-7); in that case the store is suppressed and dataout=0.
REQ-022 addr_err SHALL be combinational and independent of DMwrite.

Reset
REQ-023 Asserting reset SHALL immediately force state=CLEAR, clr_ptr=0, and busy=1.
REQ-024 While reset is held, no array write occurs; clearing starts on the first edge after release.
REQ-025 Reset asserted mid-clear SHALL restart clearing from word 0.
REQ-026 Array contents are not reset asynchronously; values after the reset edge come from the clear sequence only.

Configuration
REQ-027 Macro DM_TRACE_EN defined: each accepted store prints "%d@%h: *%h <= %h" with $time, PC8_M-8, word-aligned Addr, and the merged 32-bit word.
REQ-028 Macro DM_TRACE_EN undefined: no trace is printed, and PC8_M is unused.

Structure
REQ-029 Package dm_pkg SHALL hold the ls_type encodings (LS_W=0, LS_H=1, LS_HU=2, LS_B=3, LS_BU=4) and the state enum.
REQ-030 Sub-module dm_lane_align SHALL hold the combinational logic: byte-enable generation, store merge, load extract/extend, and misalign detection.
REQ-031 The top level SHALL hold the array, the clear FSM, and the trace.

Verification
REQ-032 Release reset, count edges -> busy falls after exactly DEPTH edges; a read of any word returns 0.
REQ-033 Store LS_W 0x12345678 at 0x10, then LS_B 0xAB at 0x11 -> a word read at 0x10 gives 0x1234AB78.
REQ-034 Word at 0x20 = 0x80FF7F01; reads: LS_B @0x22 -> 0xFFFFFFFF; LS_BU @0x23 -> 0x00000080; LS_H @0x22 -> 0xFFFF80FF; LS_HU @0x20 -> 0x00007F01.
REQ-035 LS_W store at 0x06, or LS_H at 0x05, or ls_type=6 -> addr_err=1 and memory unchanged.
REQ-036 Assert reset at clear edge 100, release, store during busy -> busy lasts DEPTH edges again and the store is dropped.
REQ-037 With DEPTH=1024, store at 0x1004 -> the word read at 0x0004 returns the stored data (wrap).
